// File: rtl/flex_counter_pkg.sv
// Shared constants and helpers for the flexible counter bank.
package flex_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int DEFAULT_CNT_BITS = 4;
    localparam int MAX_CNT_BITS     = 32;

    // Terminal value: the limit when counting up, one when counting down.
    function automatic logic [MAX_CNT_BITS-1:0] terminal_sel(
        input logic                    dir,
        input logic [MAX_CNT_BITS-1:0] limit
    );
        return (dir == DIR_DOWN) ? MAX_CNT_BITS'(1) : limit;
    endfunction

endpackage

// File: rtl/flex_counter_bank_if.sv
// Packed per-channel control and status buses of the counter bank.
// FLEX_COUNTER_BANK_IRQ_EN adds the sticky interrupt signals.
interface flex_counter_bank_if
    import flex_counter_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int NUM_CNT_BITS = DEFAULT_CNT_BITS
);
    logic [NUM_CH-1:0]              clear;
    logic [NUM_CH-1:0]              count_enable;
    logic [NUM_CH-1:0]              count_down;
    logic [NUM_CH-1:0]              sat_mode;
    logic [NUM_CH-1:0]              load;
    logic [NUM_CH*NUM_CNT_BITS-1:0] load_val;
    logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val;
    logic [NUM_CH*NUM_CNT_BITS-1:0] count_out;
    logic [NUM_CH-1:0]              rollover_flag;
    logic [NUM_CH-1:0]              rollover_pulse;
`ifdef FLEX_COUNTER_BANK_IRQ_EN
    logic [NUM_CH-1:0]              irq_clear;
    logic [NUM_CH-1:0]              irq_status;
    logic                           irq;
`endif

    modport master (
        output clear, count_enable, count_down, sat_mode, load, load_val, rollover_val,
        input  count_out, rollover_flag, rollover_pulse
`ifdef FLEX_COUNTER_BANK_IRQ_EN
        , output irq_clear, input irq_status, irq
`endif
    );

    modport slave (
        input  clear, count_enable, count_down, sat_mode, load, load_val, rollover_val,
        output count_out, rollover_flag, rollover_pulse
`ifdef FLEX_COUNTER_BANK_IRQ_EN
        , input irq_clear, output irq_status, irq
`endif
    );
endinterface

// File: rtl/flex_counter_ch.sv
// One flexible counter channel: up/down, load, wrap/saturate, flag and pulse.
module flex_counter_ch
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = DEFAULT_CNT_BITS
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic                    sat_mode,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    rollover_pulse
);
    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] next_count;
    logic [NUM_CNT_BITS-1:0] term_val;
    logic                    limit_zero;
    logic                    at_term;

    always_comb begin
        term_val   = NUM_CNT_BITS'(terminal_sel(count_down, MAX_CNT_BITS'(rollover_val)));
        limit_zero = (rollover_val == '0);
        next_count = count_out;
        if (clear) begin
            next_count = '0;
        end else if (load) begin
            next_count = load_val;
        end else if (count_enable && !limit_zero) begin
            // Out-of-range counts (e.g. after a raw load) snap to the terminal path.
            if (count_down == DIR_UP) begin
                if (count_out >= rollover_val)
                    next_count = (sat_mode == MODE_SAT) ? rollover_val : ONE;
                else
                    next_count = count_out + ONE;
            end else begin
                if (count_out <= ONE)
                    next_count = (sat_mode == MODE_SAT) ? ONE : rollover_val;
                else
                    next_count = count_out - ONE;
            end
        end
        at_term = (next_count == term_val) && !limit_zero;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out      <= '0;
            rollover_flag  <= 1'b0;
            rollover_pulse <= 1'b0;
        end else begin
            count_out      <= next_count;
            rollover_flag  <= at_term;
            // Pulse only on a counted arrival, never while holding or after load/clear.
            rollover_pulse <= at_term && count_enable && !clear && !load &&
                              (count_out != next_count);
        end
    end

endmodule

// File: rtl/flex_counter_bank.sv
// Bank of independent flexible counters; slices the packed buses per channel.
// Optional sticky interrupt logic is built when FLEX_COUNTER_BANK_IRQ_EN is defined.
module flex_counter_bank
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = DEFAULT_CNT_BITS,
    parameter int NUM_CH       = 4
) (
    input logic                 clk,
    input logic                 n_rst,
    flex_counter_bank_if.slave  bus
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        flex_counter_ch #(
            .NUM_CNT_BITS(NUM_CNT_BITS)
        ) u_ch (
            .clk           (clk),
            .n_rst         (n_rst),
            .clear         (bus.clear[i]),
            .count_enable  (bus.count_enable[i]),
            .count_down    (bus.count_down[i]),
            .sat_mode      (bus.sat_mode[i]),
            .load          (bus.load[i]),
            .load_val      (bus.load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_val  (bus.rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .count_out     (bus.count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_flag (bus.rollover_flag[i]),
            .rollover_pulse(bus.rollover_pulse[i])
        );
    end

`ifdef FLEX_COUNTER_BANK_IRQ_EN
    // A new pulse beats a coincident clear so no rollover is ever lost.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.irq_status <= '0;
            bus.irq        <= 1'b0;
        end else begin
            bus.irq_status <= (bus.irq_status & ~bus.irq_clear) | bus.rollover_pulse;
            bus.irq        <= |bus.irq_status;
        end
    end
`endif

endmodule
